// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial add/subtract unit.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational one-bit full adder cell used by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract unit, LSB-first through one full adder.
// Optional abort port enabled by defining SERIAL_ADDER_ABORT_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
`ifdef SERIAL_ADDER_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-2:0]   res_sr_q, res_sr_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  logic               fa_sum, fa_cout;
  logic               last_bit;
  logic               abort_hit;
  logic [WIDTH-1:0]   shifted;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0] ^ sub_q),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

`ifdef SERIAL_ADDER_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign last_bit = (count_q == CW'(WIDTH - 1));
  // The final sum bit never needs to sit in the shift register; it goes straight into result.
  assign shifted  = {fa_sum, res_sr_q};

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_sr_d    = res_sr_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    count_d     = count_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          sub_d   = sub;
          carry_d = sub;
          count_d = '0;
        end
      end
      ST_SHIFT: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
        end else begin
          a_sr_d   = a_sr_q >> 1;
          b_sr_d   = b_sr_q >> 1;
          res_sr_d = shifted[WIDTH-1:1];
          carry_d  = fa_cout;
          if (last_bit) begin
            state_d     = ST_DONE;
            result_d    = shifted;
            carry_out_d = fa_cout;
            overflow_d  = carry_q ^ fa_cout;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_sr_q    <= res_sr_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
